// File: rtl/systolic_processor_vcounter.sv
// Output-stationary SIZE x SIZE systolic multiplier for unsigned matrices.
// A cycle counter closes the accumulation window so the product stays frozen.
module systolic_processor_vcounter #(
    parameter int SIZE   = 4,
    parameter int I_BITS = 8,
    parameter int O_BITS = 2 * I_BITS + $clog2(SIZE)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [SIZE*I_BITS-1:0]        i_a_full,
    input  logic [SIZE*I_BITS-1:0]        i_b_full,
    output logic [SIZE*SIZE*O_BITS-1:0]   o_c_full
);

    localparam int CW    = $clog2(3 * SIZE) + 1;
    localparam int LIMIT = 3 * SIZE - 2;
    localparam int PW    = 2 * I_BITS;

    logic [CW-1:0] count;
    logic          enable;

    assign enable = count < CW'(LIMIT);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Last column/row registers have no consumer, so only SIZE-1 are kept.
    logic [I_BITS-1:0] a_pipe [SIZE][SIZE-1];
    logic [I_BITS-1:0] b_pipe [SIZE-1][SIZE];
    logic [I_BITS-1:0] a_in   [SIZE][SIZE];
    logic [I_BITS-1:0] b_in   [SIZE][SIZE];
    logic [O_BITS-1:0] acc    [SIZE][SIZE];

    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            logic [PW-1:0] prod;

            if (c == 0) begin : g_a_edge
                assign a_in[r][c] = i_a_full[I_BITS*r +: I_BITS];
            end else begin : g_a_link
                assign a_in[r][c] = a_pipe[r][c-1];
            end

            if (r == 0) begin : g_b_edge
                assign b_in[r][c] = i_b_full[I_BITS*c +: I_BITS];
            end else begin : g_b_link
                assign b_in[r][c] = b_pipe[r-1][c];
            end

            assign prod = PW'(a_in[r][c]) * PW'(b_in[r][c]);

            always_ff @(posedge i_clock or negedge i_reset) begin
                if (!i_reset) begin
                    acc[r][c] <= '0;
                end else if (enable) begin
                    acc[r][c] <= acc[r][c] + O_BITS'(prod);
                end
            end

            if (c < SIZE - 1) begin : g_a_reg
                always_ff @(posedge i_clock or negedge i_reset) begin
                    if (!i_reset) begin
                        a_pipe[r][c] <= '0;
                    end else if (enable) begin
                        a_pipe[r][c] <= a_in[r][c];
                    end
                end
            end

            if (r < SIZE - 1) begin : g_b_reg
                always_ff @(posedge i_clock or negedge i_reset) begin
                    if (!i_reset) begin
                        b_pipe[r][c] <= '0;
                    end else if (enable) begin
                        b_pipe[r][c] <= b_in[r][c];
                    end
                end
            end

            assign o_c_full[O_BITS*(r*SIZE+c) +: O_BITS] = acc[r][c];
        end
    end

endmodule

// File: tb/tb_systolic_processor_vcounter.sv
// Bench for systolic_processor_vcounter: 4x4 vectors and corners, random 4x4 and 8x8
// products against a plain matrix-multiply reference.
module tb_systolic_processor_vcounter;

    localparam int S4 = 4;
    localparam int S8 = 8;
    localparam int IB = 8;
    localparam int O4 = 18;
    localparam int O8 = 19;
    localparam int BW = S8 * S8 * O8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst4, rst8;
    logic [S4*IB-1:0]        a4, b4;
    logic [S8*IB-1:0]        a8, b8;
    logic [S4*S4*O4-1:0]     c4;
    logic [S8*S8*O8-1:0]     c8;

    systolic_processor_vcounter #(.SIZE(S4), .I_BITS(IB)) dut4 (
        .i_clock (clk),
        .i_reset (rst4),
        .i_a_full(a4),
        .i_b_full(b4),
        .o_c_full(c4)
    );

    systolic_processor_vcounter #(.SIZE(S8), .I_BITS(IB)) dut8 (
        .i_clock (clk),
        .i_reset (rst8),
        .i_a_full(a8),
        .i_b_full(b8),
        .o_c_full(c8)
    );

    typedef struct packed {
        logic [15:0][7:0]  a;
        logic [15:0][7:0]  b;
        logic [15:0][17:0] c;
    } vec_t;

    int    ma [8][8];
    int    mb [8][8];
    longint gc [8][8];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [BW-1:0] act,
                         input logic [BW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: C = A*B with plain arithmetic, wrapped to ob bits.
    task automatic gold(input int n, input int ob);
        longint s;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                s = 0;
                for (int k = 0; k < n; k++)
                    s += longint'(ma[r][k]) * longint'(mb[k][c]);
                gc[r][c] = s & ((longint'(1) << ob) - 1);
            end
    endtask

    function automatic logic [BW-1:0] pack_gold(input int n, input int ob);
        logic [BW-1:0] e = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                for (int i = 0; i < ob; i++)
                    e[ob*(r*n+c) + i] = gc[r][c][i];
        return e;
    endfunction

    // Skewed schedule: lane r carries A[r][t-r], lane c carries B[t-c][c].
    task automatic set4(input int t);
        for (int i = 0; i < S4; i++) begin
            a4[IB*i +: IB] = '0;
            b4[IB*i +: IB] = '0;
            if (t - i >= 0 && t - i < S4) begin
                a4[IB*i +: IB] = IB'(ma[i][t-i]);
                b4[IB*i +: IB] = IB'(mb[t-i][i]);
            end
        end
    endtask

    task automatic set8(input int t);
        for (int i = 0; i < S8; i++) begin
            a8[IB*i +: IB] = '0;
            b8[IB*i +: IB] = '0;
            if (t - i >= 0 && t - i < S8) begin
                a8[IB*i +: IB] = IB'(ma[i][t-i]);
                b8[IB*i +: IB] = IB'(mb[t-i][i]);
            end
        end
    endtask

    task automatic run4(input int edges);
        rst4 = 1'b0;
        a4 = '0;
        b4 = '0;
        @(negedge clk);
        rst4 = 1'b1;
        for (int t = 0; t < edges; t++) begin
            set4(t);
            @(negedge clk);
        end
        a4 = '0;
        b4 = '0;
    endtask

    task automatic run8(input int edges);
        rst8 = 1'b0;
        a8 = '0;
        b8 = '0;
        @(negedge clk);
        rst8 = 1'b1;
        for (int t = 0; t < edges; t++) begin
            set8(t);
            @(negedge clk);
        end
        a8 = '0;
        b8 = '0;
    endtask

    task automatic load_vec(input vec_t v);
        for (int r = 0; r < S4; r++)
            for (int c = 0; c < S4; c++) begin
                ma[r][c] = int'(v.a[r*S4+c]);
                mb[r][c] = int'(v.b[r*S4+c]);
            end
    endtask

    vec_t          tbl [3];
    logic [BW-1:0] held;

    initial begin
        rst4 = 1'b0;
        rst8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;

        // identity x (4k+c+1), all-255, ones x column index
        for (int i = 0; i < 16; i++) begin
            tbl[0].a[i] = (i / 4 == i % 4) ? 8'd1 : 8'd0;
            tbl[0].b[i] = 8'(i + 1);
            tbl[0].c[i] = 18'(i + 1);
            tbl[1].a[i] = 8'd255;
            tbl[1].b[i] = 8'd255;
            tbl[1].c[i] = 18'd260100;
            tbl[2].a[i] = 8'd1;
            tbl[2].b[i] = 8'(i % 4 + 1);
            tbl[2].c[i] = 18'(4 * (i % 4 + 1));
        end

        // reset holds outputs at zero even with busy lanes
        for (int t = 0; t < 3; t++) begin
            a4 = $urandom; b4 = $urandom;
            @(negedge clk);
        end
        check("reset_hold", BW'(c4), '0);

        for (int v = 0; v < 3; v++) begin
            load_vec(tbl[v]);
            run4(3 * S4 - 2);
            check($sformatf("table_%0d", v), BW'(c4), BW'(tbl[v].c));
        end

        // frozen: 20 cycles of nonzero lanes after completion
        held = BW'(c4);
        for (int t = 0; t < 20; t++) begin
            a4 = $urandom | 32'h0101_0101;
            b4 = $urandom | 32'h0101_0101;
            @(negedge clk);
        end
        check("freeze", BW'(c4), held);

        // per-element latency: C[0][0] final after 4 edges, C[3][3] not yet after 9
        load_vec(tbl[0]);
        run4(S4);
        check("c00_early", BW'(c4[O4-1:0]), BW'(1));
        load_vec(tbl[0]);
        run4(3 * S4 - 3);
        check("c33_not_yet", BW'(c4[O4*15 +: O4]), BW'(0));

        // reset mid-run at cycle 5, then rerun identity
        load_vec(tbl[0]);
        rst4 = 1'b0;
        @(negedge clk);
        rst4 = 1'b1;
        for (int t = 0; t < 5; t++) begin
            set4(t);
            @(negedge clk);
        end
        check("pre_midreset_busy", BW'(c4 != '0), BW'(1));
        rst4 = 1'b0;
        #1;
        check("midreset_zero", BW'(c4), '0);
        gold(S4, O4);
        run4(3 * S4 - 2);
        check("rerun_identity", BW'(c4), pack_gold(S4, O4));

        // asynchronous reset mid-cycle
        a4 = $urandom | 32'h0101_0101;
        b4 = $urandom | 32'h0101_0101;
        @(posedge clk);
        #2;
        rst4 = 1'b0;
        #1;
        check("async_reset", BW'(c4), '0);

        for (int it = 0; it < 5; it++) begin
            for (int r = 0; r < S4; r++)
                for (int c = 0; c < S4; c++) begin
                    ma[r][c] = int'($urandom_range(0, 255));
                    mb[r][c] = int'($urandom_range(0, 255));
                end
            gold(S4, O4);
            run4(3 * S4 - 2);
            check($sformatf("rand4_%0d", it), BW'(c4), pack_gold(S4, O4));
        end

        for (int it = 0; it < 5; it++) begin
            for (int r = 0; r < S8; r++)
                for (int c = 0; c < S8; c++) begin
                    ma[r][c] = (it == 0) ? 255 : int'($urandom_range(0, 255));
                    mb[r][c] = (it == 0) ? 255 : int'($urandom_range(0, 255));
                end
            gold(S8, O8);
            run8(3 * S8 - 2);
            check($sformatf("rand8_%0d", it), c8, pack_gold(S8, O8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_processor_vcounter.md
# systolic_processor_vcounter

Output-stationary systolic matrix multiplier. Computes C = A·B for two SIZE×SIZE unsigned matrices. Operands are streamed in pre-skewed, one row lane and one column lane per array edge per cycle. An internal cycle counter (the "V counter") bounds the accumulation window so the product is frozen and held on the flat output bus. The block sits between an upstream skew/feeder stage and a downstream result consumer; it has no handshake signals.

## Interface
Parameters:
- SIZE, default 4: matrix dimension (array is SIZE×SIZE PEs); legal range ≥ 2.
- I_BITS, default 8: width of each unsigned input element.
- O_BITS, default 2*I_BITS+$clog2(SIZE) (18 at defaults): width of each accumulator/output element.

Ports:
- i_clock, in, 1: single clock; all state updates on rising edge.
- i_reset, in, 1: asynchronous, active-low reset.
- i_a_full, in, SIZE*I_BITS: A-side lanes.
  - Lane r occupies bits [I_BITS*r +: I_BITS] and feeds PE row r from the left.
- i_b_full, in, SIZE*I_BITS: B-side lanes.
  - Lane c occupies bits [I_BITS*c +: I_BITS] and feeds PE column c from the top.
- o_c_full, out, SIZE*SIZE*O_BITS: result elements.
  - Element k = r*SIZE+c occupies bits [O_BITS*k +: O_BITS] and equals C[r][c].

## Operation
- PE(r,c) contains:
  - an a-register (passes right),
  - a b-register (passes down),
  - an O_BITS accumulator.
- PE inputs:
  - a_in: PE(r,0) takes i_a_full lane r; PE(r,c>0) takes PE(r,c-1).a_reg.
  - b_in: PE(0,c) takes i_b_full lane c; PE(r>0,c) takes PE(r-1,c).b_reg.
- When enabled, every edge:
  - acc <= acc + a_in*b_in;
  - a_reg <= a_in;
  - b_reg <= b_in.
- Arithmetic:
  - all unsigned;
  - product is 2*I_BITS wide, zero-extended to O_BITS;
  - accumulation wraps modulo 2^O_BITS (no saturation).
- o_c_full is driven directly from the accumulators (no extra output register).
- V counter:
  - width $clog2(3*SIZE)+1;
  - cleared by reset;
  - increments each edge while count < 3*SIZE-2;
  - saturates at 3*SIZE-2.
- Enable = (count < 3*SIZE-2). When enable is low:
  - accumulators and a/b registers hold;
  - input lanes are ignored;
  - results stay stable until the next reset.
- Required input schedule, with cycle 0 being the first edge after i_reset deasserts:
  - lane r of i_a_full carries A[r][k] at cycle r+k;
  - lane c of i_b_full carries B[k][c] at cycle c+k;
  - all lanes carry 0 at every other cycle.

## Timing
- Reset (i_reset=0, asynchronous): all accumulators, a/b registers and the counter are 0, so o_c_full is 0 immediately.
- Each PE(r,c) receives the matching pair A[r][k], B[k][c] at edge r+c+k.
- Latency:
  - last product (PE(SIZE-1,SIZE-1), k=SIZE-1) accumulates at edge 3*SIZE-3;
  - the full C is valid after edge 3*SIZE-3, i.e. after 3*SIZE-2 edges;
  - C[r][c] alone is final after edge r+c+SIZE-1.
- From edge 3*SIZE-2 onward, outputs are frozen regardless of input activity.
- Reset asserted mid-operation: everything clears at once; a new computation starts at cycle 0 after release.
- No ready/valid handshake. Completion is implied by the fixed latency.

## Test plan
- Reset check:
  - drive random lanes while i_reset=0, then also assert i_reset asynchronously mid-cycle;
  - o_c_full must be 0 at once.
- Identity test (SIZE=4, I_BITS=8):
  - A = I, B[k][c] = 4k+c+1, with the skewed schedule;
  - after 10 edges, element k equals k+1 (1..16).
- Max-value test:
  - all A and B elements = 255;
  - after 10 edges, every element = 260100 (no wrap at O_BITS=18).
- Freeze test:
  - after a completed multiply, drive nonzero lanes for 20 more cycles;
  - o_c_full must remain unchanged.
- Reset mid-run:
  - assert i_reset at cycle 5 of a multiply;
  - outputs go to 0;
  - rerun the identity test; results match the golden model (C = A·B).
- Random test, SIZE=8, I_BITS=8:
  - random A and B;
  - after 22 edges, o_c_full matches a golden A·B computed with 19-bit elements.
